bit_demux_collector: RTL and testbench

- Inverse of the parameterised bit-select mux: accepts a stream of (bit, index) pairs and writes each bit into slot `in_sel` of an OUT_WIDTH-bit register.
- Once every slot has been written, it presents the assembled word on a valid/ready output.
- Sits downstream of any mux-based serialiser and rebuilds the parallel word it selected from.

---
 rtl/demux_pkg.sv | 26 ++
 rtl/sel_decoder.sv | 25 ++
 rtl/bit_demux_collector.sv | 114 +++++++++++
 tb/tb_bit_demux_collector.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and helpers for the bit demux collector.
// Optional flush support is selected with the DEMUX_FLUSH_EN macro in the top level.
package demux_pkg;

  // Two-state controller: gather bits, then hold the assembled word.
  typedef logic state_t;

  localparam state_t COLLECT = 1'b0;
  localparam state_t HOLD    = 1'b1;

  // Widest word the fill-mask helper can describe.
  localparam int unsigned MaxOutWidth = 64;

  // All-ones mask of the given width, right-aligned. Used to detect a fully populated word.
  function automatic logic [MaxOutWidth-1:0] fill_mask(input int unsigned width);
    logic [MaxOutWidth-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MaxOutWidth; i++) begin
      if (i < width) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/sel_decoder.sv
// Slot index decoder: turns a binary slot index into a one-hot write enable
// and flags indices that point past the last slot.
module sel_decoder #(
  parameter int unsigned SEL_WIDTH = 2,
  parameter int unsigned OUT_WIDTH = 4
) (
  input  logic [SEL_WIDTH-1:0] in_sel,
  output logic [OUT_WIDTH-1:0] wr_en,
  output logic                 out_of_range
);

  // Zero-extend so the compare is unsigned and independent of SEL_WIDTH.
  logic [31:0] sel_ext;
  assign sel_ext = 32'(in_sel);

  // One-hot decode plus range flag; an out-of-range index enables no slot.
  always_comb begin
    wr_en        = '0;
    out_of_range = (sel_ext >= OUT_WIDTH);
    for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
      wr_en[i] = (sel_ext == i);
    end
  end

endmodule

// File: rtl/bit_demux_collector.sv
// Bit demux collector: writes a stream of (bit, index) pairs into the slots of a
// word and presents the word on a valid/ready output once every slot is written.
// Define DEMUX_FLUSH_EN to add the flush input and out_mask output, which allow a
// partially filled word to be emitted early.
module bit_demux_collector
  import demux_pkg::*;
#(
  parameter int unsigned SEL_WIDTH = 2,
  parameter int unsigned OUT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_bit,
  input  logic [SEL_WIDTH-1:0] in_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
`ifdef DEMUX_FLUSH_EN
  input  logic                 flush,
  output logic [OUT_WIDTH-1:0] out_mask,
`endif
  output logic                 err_sel
);

  localparam logic [OUT_WIDTH-1:0] FullMask = OUT_WIDTH'(fill_mask(OUT_WIDTH));

  state_t                 state_q, state_d;
  logic [OUT_WIDTH-1:0]   data_q, data_d;
  logic [OUT_WIDTH-1:0]   filled_q, filled_d;
  logic                   err_q, err_d;

  logic [OUT_WIDTH-1:0]   wr_en;
  logic                   out_of_range;
  logic                   in_fire;
  logic                   out_fire;

  sel_decoder #(
    .SEL_WIDTH (SEL_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sel_decoder (
    .in_sel       (in_sel),
    .wr_en        (wr_en),
    .out_of_range (out_of_range)
  );

  // Handshakes and outputs derive straight from state so reset drops them at once.
  always_comb begin
    in_ready  = (state_q == COLLECT);
    out_valid = (state_q == HOLD);
    out_data  = data_q;
    err_sel   = err_q;
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
  end

`ifdef DEMUX_FLUSH_EN
  // filled_q is all-ones after a complete word and the partial fill after a flush.
  always_comb begin
    out_mask = filled_q;
  end
`endif

  // Next-state: merge accepted bits, detect completion or flush, clear on consume.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    filled_d = filled_q;
    err_d    = 1'b0;

    if (state_q == COLLECT) begin
      if (in_fire) begin
        if (out_of_range) begin
          err_d = 1'b1;
        end else begin
          data_d   = (data_q & ~wr_en) | (wr_en & {OUT_WIDTH{in_bit}});
          filled_d = filled_q | wr_en;
        end
      end
      if (filled_d == FullMask) begin
        state_d = HOLD;
      end
`ifdef DEMUX_FLUSH_EN
      // Flush sees the fill including any write accepted this same cycle.
      else if (flush && (filled_d != '0)) begin
        state_d = HOLD;
      end
`endif
    end else begin
      if (out_fire) begin
        data_d   = '0;
        filled_d = '0;
        state_d  = COLLECT;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      data_q   <= '0;
      filled_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      filled_q <= filled_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_bit_demux_collector.sv
// Directed self-checking bench for bit_demux_collector: a default 4-slot instance
// and a 5-slot / 3-bit-index instance exercising out-of-range indices.
module tb_bit_demux_collector;

  logic clk;
  logic rst_n;

  // Default instance (SEL_WIDTH=2, OUT_WIDTH=4).
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic [1:0] in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       err_sel;

  // Wide instance (SEL_WIDTH=3, OUT_WIDTH=5).
  logic       w_in_valid;
  logic       w_in_ready;
  logic       w_in_bit;
  logic [2:0] w_in_sel;
  logic       w_out_valid;
  logic       w_out_ready;
  logic [4:0] w_out_data;
  logic       w_err_sel;

`ifdef DEMUX_FLUSH_EN
  logic       flush;
  logic [3:0] out_mask;
  logic       w_flush;
  logic [4:0] w_out_mask;
`endif

  int n_checks;
  int n_errors;

  bit_demux_collector #(
    .SEL_WIDTH (2),
    .OUT_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef DEMUX_FLUSH_EN
    .flush     (flush),
    .out_mask  (out_mask),
`endif
    .err_sel   (err_sel)
  );

  bit_demux_collector #(
    .SEL_WIDTH (3),
    .OUT_WIDTH (5)
  ) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_bit    (w_in_bit),
    .in_sel    (w_in_sel),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_data  (w_out_data),
`ifdef DEMUX_FLUSH_EN
    .flush     (w_flush),
    .out_mask  (w_out_mask),
`endif
    .err_sel   (w_err_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic b);
    in_valid = 1'b1;
    in_sel   = sel;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic w_send(input logic [2:0] sel, input logic b);
    w_in_valid = 1'b1;
    w_in_sel   = sel;
    w_in_bit   = b;
    tick();
    w_in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    in_sel      = '0;
    out_ready   = 1'b0;
    w_in_valid  = 1'b0;
    w_in_bit    = 1'b0;
    w_in_sel    = '0;
    w_out_ready = 1'b0;
`ifdef DEMUX_FLUSH_EN
    flush       = 1'b0;
    w_flush     = 1'b0;
`endif
    #12;
    rst_n = 1'b1;
    tick();

    // Reset state.
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_err_sel", err_sel, 0);
    check("rst_w_in_ready", w_in_ready, 1);
`ifdef DEMUX_FLUSH_EN
    check("rst_out_mask", out_mask, 0);
`endif

    // Vector 1: slots 0..3 with bits 1,1,0,0.
    send(2'd0, 1'b1);
    send(2'd1, 1'b1);
    send(2'd2, 1'b0);
    check("v1_no_valid_early", out_valid, 0);
    send(2'd3, 1'b0);
    check("v1_out_valid", out_valid, 1);
    check("v1_out_data", out_data, 4'b0011);
    check("v1_in_ready_low", in_ready, 0);
`ifdef DEMUX_FLUSH_EN
    check("v1_out_mask", out_mask, 4'b1111);
`endif
    consume();
    check("v1_consumed", out_valid, 0);
    check("v1_in_ready_back", in_ready, 1);

    // Vector 2: slot rewrite; completes only on the 5th write.
    send(2'd2, 1'b1);
    send(2'd2, 1'b0);
    send(2'd0, 1'b1);
    send(2'd1, 1'b1);
    check("v2_no_valid_4th", out_valid, 0);
    send(2'd3, 1'b1);
    check("v2_out_valid", out_valid, 1);
    check("v2_out_data", out_data, 4'b1011);

    // Vector 3: back-pressure for 10 cycles while in_valid stays high.
    in_valid = 1'b1;
    in_sel   = 2'd0;
    in_bit   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("v3_in_ready", in_ready, 0);
      check("v3_hold_data", out_data, 4'b1011);
      check("v3_hold_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    consume();
    check("v3_consumed", out_valid, 0);

    // Vector 4: wide instance, out-of-range indices 6, 5, 7.
    w_send(3'd6, 1'b1);
    check("w_err_pulse6", w_err_sel, 1);
    tick();
    check("w_err_clear6", w_err_sel, 0);
    w_send(3'd5, 1'b1);
    check("w_err_pulse5", w_err_sel, 1);
    w_send(3'd7, 1'b1);
    check("w_err_pulse7", w_err_sel, 1);
    tick();
    check("w_err_clear7", w_err_sel, 0);
    w_send(3'd0, 1'b1);
    w_send(3'd1, 1'b1);
    w_send(3'd2, 1'b1);
    w_send(3'd3, 1'b1);
    check("w_no_valid_4", w_out_valid, 0);
    check("w_no_err_valid", w_err_sel, 0);
    w_send(3'd4, 1'b1);
    check("w_out_valid", w_out_valid, 1);
    check("w_out_data", w_out_data, 5'b11111);
    w_out_ready = 1'b1;
    tick();
    w_out_ready = 1'b0;
    check("w_consumed", w_out_valid, 0);

    // Vector 5: asynchronous reset mid-collection discards partial data.
    send(2'd0, 1'b1);
    send(2'd1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", in_ready, 1);
    #3;
    rst_n = 1'b1;
    tick();
    send(2'd0, 1'b0);
    send(2'd1, 1'b0);
    send(2'd2, 1'b0);
    check("v5_no_valid_3", out_valid, 0);
    send(2'd3, 1'b0);
    check("v5_out_valid", out_valid, 1);
    check("v5_out_data", out_data, 4'b0000);

    // Reset during HOLD drops out_valid before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_hold_out_valid", out_valid, 0);
    check("rst_hold_in_ready", in_ready, 1);
    #3;
    rst_n = 1'b1;
    tick();

`ifdef DEMUX_FLUSH_EN
    // Vector 6: flush a partial word, then flush with nothing filled.
    send(2'd1, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_out_valid", out_valid, 1);
    check("fl_out_data", out_data, 4'b0010);
    check("fl_out_mask", out_mask, 4'b0010);
    consume();
    check("fl_consumed", out_valid, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_empty_ignored", out_valid, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
